tone_decoder: RTL

// - Receive side of the music-box tone path: measures the period of an incoming square wave
//   (bell format) and decodes it into one of the 16 pitches (indices 0..15, same index order as SW).
// - Sits beside the tone generator; drives LEDs and a self-test loopback (bell -> tone_in).

---
 rtl/tone_pkg.sv | 50 +++++
 rtl/tone_sync_edge.sv | 25 ++
 rtl/tone_decoder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared pitch table and FSM encoding for the tone generator and tone decoder.
// Pitch k is the half-period count at band 1, taken from the clock divider and the note frequency.
package tone_pkg;

   localparam int unsigned CLK_DIV   = 50_000_000;
   localparam int unsigned NUM_NOTES = 16;

   typedef enum logic [1:0] {IDLE, MEASURE, SEARCH} state_e;

   function automatic int unsigned note_freq(input int unsigned k);
      int unsigned f;
      case (k)
         0:       f = 1865;
         1:       f = 1976;
         2:       f = 2093;
         3:       f = 2217;
         4:       f = 2349;
         5:       f = 2489;
         6:       f = 2637;
         7:       f = 2794;
         8:       f = 2960;
         9:       f = 3136;
         10:      f = 3322;
         11:      f = 3520;
         12:      f = 3729;
         13:      f = 3951;
         14:      f = 4186;
         default: f = 4434;
      endcase
      return f;
   endfunction

   localparam int unsigned PITCH_0  = CLK_DIV / note_freq(0);
   localparam int unsigned PITCH_1  = CLK_DIV / note_freq(1);
   localparam int unsigned PITCH_2  = CLK_DIV / note_freq(2);
   localparam int unsigned PITCH_3  = CLK_DIV / note_freq(3);
   localparam int unsigned PITCH_4  = CLK_DIV / note_freq(4);
   localparam int unsigned PITCH_5  = CLK_DIV / note_freq(5);
   localparam int unsigned PITCH_6  = CLK_DIV / note_freq(6);
   localparam int unsigned PITCH_7  = CLK_DIV / note_freq(7);
   localparam int unsigned PITCH_8  = CLK_DIV / note_freq(8);
   localparam int unsigned PITCH_9  = CLK_DIV / note_freq(9);
   localparam int unsigned PITCH_10 = CLK_DIV / note_freq(10);
   localparam int unsigned PITCH_11 = CLK_DIV / note_freq(11);
   localparam int unsigned PITCH_12 = CLK_DIV / note_freq(12);
   localparam int unsigned PITCH_13 = CLK_DIV / note_freq(13);
   localparam int unsigned PITCH_14 = CLK_DIV / note_freq(14);
   localparam int unsigned PITCH_15 = CLK_DIV / note_freq(15);

endpackage

// File: rtl/tone_sync_edge.sv
// Two-flop synchronizer for the asynchronous tone input plus a registered rising-edge pulse.
// The pulse appears three clocks after the input rises.
module tone_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic [2:0] sync_q;
   logic       rise_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], din};
         rise_q <= sync_q[1] & ~sync_q[2];
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/tone_decoder.sv
// Measures the period of the incoming tone and decodes it to one of 16 pitches, searching
// the expected-period table one index per clock and requiring repeated equal matches to lock.
module tone_decoder
   import tone_pkg::*;
#(
   parameter int unsigned CNT_W      = 24,
   parameter int unsigned TOL_SHIFT  = 6,
   parameter int unsigned STABLE_CNT = 3,
   parameter int unsigned MAX_PERIOD = 1_000_000,
   parameter int unsigned CLK_HZ     = CLK_DIV
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tone_in,
   input  logic [3:0]       band,
   output logic             note_valid,
   output logic [3:0]       note_idx,
   output logic [15:0]      note_onehot,
   output logic [CNT_W-1:0] period
);

   localparam int unsigned STAB_W = $clog2(STABLE_CNT + 1);

   logic             rise;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, p_q, p_d, period_q, period_d;
   logic [3:0]       k_q, k_d, cand_q, cand_d, idx_q, idx_d;
   logic             cand_vld_q, cand_vld_d, valid_q, valid_d;
   logic [STAB_W-1:0] stab_q, stab_d;
   logic [15:0]      onehot_q, onehot_d;

   logic [CNT_W-1:0] pitch_tab [NUM_NOTES];
   logic [CNT_W-1:0] prod, e_k, tol, diff;
   logic             hit;

   tone_sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (tone_in),
      .rise  (rise)
   );

   for (genvar i = 0; i < NUM_NOTES; i++) begin : g_pitch
      assign pitch_tab[i] = CNT_W'(CLK_HZ / note_freq(i));
   end

   // E_k = 2*(band*pitch_k + 1); band 0 never matches
   assign prod = CNT_W'(band) * pitch_tab[k_q];
   assign e_k  = {prod[CNT_W-2:0], 1'b0} + CNT_W'(2);
   assign tol  = e_k >> TOL_SHIFT;
   assign diff = (p_q >= e_k) ? (p_q - e_k) : (e_k - p_q);
   assign hit  = (band != 4'd0) && (diff <= tol);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      p_d        = p_q;
      k_d        = k_q;
      period_d   = period_q;
      cand_d     = cand_q;
      cand_vld_d = cand_vld_q;
      stab_d     = stab_q;
      valid_d    = valid_q;
      idx_d      = idx_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rise) state_d = MEASURE;
         end
         MEASURE, SEARCH: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(MAX_PERIOD)) begin
               state_d    = IDLE;
               cnt_d      = '0;
               cand_d     = '0;
               cand_vld_d = 1'b0;
               stab_d     = '0;
               valid_d    = 1'b0;
               idx_d      = '0;
            end else if (rise) begin
               // also aborts an in-flight search; its result is simply never used
               period_d = cnt_q + CNT_W'(1);
               p_d      = cnt_q + CNT_W'(1);
               cnt_d    = '0;
               k_d      = '0;
               state_d  = SEARCH;
            end else if (state_q == SEARCH) begin
               if (hit) begin
                  state_d = MEASURE;
                  if (cand_vld_q && (cand_q == k_q)) begin
                     if (stab_q < STAB_W'(STABLE_CNT)) stab_d = stab_q + STAB_W'(1);
                  end else begin
                     cand_d     = k_q;
                     cand_vld_d = 1'b1;
                     stab_d     = STAB_W'(1);
                     valid_d    = 1'b0;
                     idx_d      = '0;
                  end
                  if (stab_d == STAB_W'(STABLE_CNT)) begin
                     valid_d = 1'b1;
                     idx_d   = cand_d;
                  end
               end else if (k_q == 4'd15) begin
                  state_d    = MEASURE;
                  cand_d     = '0;
                  cand_vld_d = 1'b0;
                  stab_d     = '0;
                  valid_d    = 1'b0;
                  idx_d      = '0;
               end else begin
                  k_d = k_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      onehot_d = valid_d ? (16'h0001 << idx_d) : 16'h0000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         p_q        <= '0;
         k_q        <= '0;
         period_q   <= '0;
         cand_q     <= '0;
         cand_vld_q <= 1'b0;
         stab_q     <= '0;
         valid_q    <= 1'b0;
         idx_q      <= '0;
         onehot_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         p_q        <= p_d;
         k_q        <= k_d;
         period_q   <= period_d;
         cand_q     <= cand_d;
         cand_vld_q <= cand_vld_d;
         stab_q     <= stab_d;
         valid_q    <= valid_d;
         idx_q      <= idx_d;
         onehot_q   <= onehot_d;
      end
   end

   assign note_valid  = valid_q;
   assign note_idx    = idx_q;
   assign note_onehot = onehot_q;
   assign period      = period_q;

endmodule
